// File: rtl/sigma_delta_decimator.sv
// Third-order CIC (sinc^3) decimator: 1-bit sigma-delta stream in, signed BW-bit PCM out.
// Decimation ratio R = 2**DEC_LOG2; output is rescaled by an arithmetic shift and saturated.
module sigma_delta_decimator #(
  parameter int unsigned BW       = 16,
  parameter int unsigned DEC_LOG2 = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 bit_i,
  input  logic                 bit_valid_i,
  output logic signed [BW-1:0] dout_o,
  output logic                 dout_valid_o,
  output logic                 sat_o
);

  localparam int unsigned W     = 2 + 3 * DEC_LOG2;
  localparam int unsigned SHIFT = 3 * DEC_LOG2 - (BW - 1);

  localparam logic [DEC_LOG2-1:0] CntMax = '1;
  localparam logic signed [W-1:0] YMax   = {{(W - BW + 1){1'b0}}, {(BW - 1){1'b1}}};
  localparam logic signed [W-1:0] YMin   = {{(W - BW + 1){1'b1}}, {(BW - 1){1'b0}}};

  if (3 * DEC_LOG2 < BW - 1) begin : g_param_check
    $error("sigma_delta_decimator: 3*DEC_LOG2 must be >= BW-1");
  end

  logic signed [W-1:0]  x;
  logic signed [W-1:0]  i1_q, i2_q, i3_q;
  logic signed [W-1:0]  d1_q, d2_q, d3_q;
  logic signed [W-1:0]  c1, c2, c3, y;
  logic [DEC_LOG2-1:0]  cnt_q;
  logic                 dec_stb_q;
  logic signed [BW-1:0] y_sat;
  logic                 clip;

  always_comb begin
    x = bit_i ? W'(1) : {W{1'b1}};
  end

  // Integrators wrap modulo 2**W on purpose; the comb differences undo the wrap exactly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      i1_q      <= '0;
      i2_q      <= '0;
      i3_q      <= '0;
      cnt_q     <= '0;
      dec_stb_q <= 1'b0;
    end else begin
      dec_stb_q <= bit_valid_i && (cnt_q == CntMax);
      if (bit_valid_i) begin
        i1_q  <= i1_q + x;
        i2_q  <= i2_q + i1_q;
        i3_q  <= i3_q + i2_q;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    c1 = i3_q - d1_q;
    c2 = c1 - d2_q;
    c3 = c2 - d3_q;
    y  = c3 >>> SHIFT;
    clip  = 1'b0;
    y_sat = y[BW-1:0];
    if (y > YMax) begin
      clip  = 1'b1;
      y_sat = YMax[BW-1:0];
    end else if (y < YMin) begin
      clip  = 1'b1;
      y_sat = YMin[BW-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d1_q         <= '0;
      d2_q         <= '0;
      d3_q         <= '0;
      dout_o       <= '0;
      sat_o        <= 1'b0;
      dout_valid_o <= 1'b0;
    end else begin
      dout_valid_o <= dec_stb_q;
      if (dec_stb_q) begin
        d1_q   <= i3_q;
        d2_q   <= c1;
        d3_q   <= c2;
        dout_o <= y_sat;
        sat_o  <= clip;
      end
    end
  end

endmodule

// File: tb/tb_sigma_delta_decimator.sv
// Scoreboard bench for sigma_delta_decimator: a polynomial-kernel FIR model predicts each output,
// a separate monitor pops and compares value, saturation flag and arrival edge.
module tb_sigma_delta_decimator;

  localparam int BW = 16;
  localparam int DL = 6;
  localparam int R  = 64;
  localparam int SH = 3 * DL - (BW - 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic signed [BW-1:0] dout;
  logic dout_valid;
  logic sat;

  sigma_delta_decimator #(.BW(BW), .DEC_LOG2(DL)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bit_i       (bit_in),
    .bit_valid_i (bit_valid),
    .dout_o      (dout),
    .dout_valid_o(dout_valid),
    .sat_o       (sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint dout;
    longint sat;
    longint edge_n;
  } exp_t;

  exp_t   expq[$];
  int     hist[$];
  longint h[3*R];
  int     cyc = 0;
  int     errors = 0;
  int     checks = 0;

  function automatic void check(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic longint f2(longint a);
    return (a >= 2) ? a * (a - 1) / 2 : 0;
  endfunction

  // sinc^3 impulse response seen at the decimation instant (includes the two-bit integrator lag).
  initial begin
    for (int j = 0; j < 3 * R; j++)
      h[j] = f2(j) - 3 * f2(j - R) + 3 * f2(j - 2 * R) - f2(j - 3 * R);
  end

  function automatic void model_accept(bit b);
    int     n;
    longint c;
    longint y;
    exp_t   e;
    hist.push_back(b ? 1 : -1);
    n = hist.size();
    if (n % R == 0) begin
      c = 0;
      for (int m = (n > 3 * R) ? n - 3 * R : 0; m < n; m++) c += hist[m] * h[n - 1 - m];
      y = c >>> SH;
      e.sat = 0;
      if (y > 32767) begin y = 32767; e.sat = 1; end
      if (y < -32768) begin y = -32768; e.sat = 1; end
      e.dout = y;
      e.edge_n = cyc + 1 + 1;
      expq.push_back(e);
    end
  endfunction

  initial forever @(posedge clk) cyc++;

  // Monitor: compares every strobe against the scoreboard, and checks hold between strobes.
  initial begin
    longint hold_d = 0;
    longint hold_s = 0;
    bit     prev_dv = 1'b0;
    exp_t   e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_d = 0; hold_s = 0; prev_dv = 1'b0;
      end else if (dout_valid) begin
        check("no_back_to_back", prev_dv, 0);
        check("output_expected", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          check("dout", dout, e.dout);
          check("sat", sat, e.sat);
          check("latency_edge", cyc, e.edge_n);
          hold_d = e.dout; hold_s = e.sat;
        end
        prev_dv = 1'b1;
      end else begin
        check("dout_hold", dout, hold_d);
        check("sat_hold", sat, hold_s);
        prev_dv = 1'b0;
      end
    end
  end

  task automatic drive(bit b, bit v);
    @(negedge clk);
    bit_in = b;
    bit_valid = v;
    if (v) model_accept(b);
  endtask

  function automatic bit pat_bit(int kind, int idx);
    case (kind)
      0: return 1'b1;
      1: return 1'b0;
      2: return (idx % 2 == 0);
      3: return (idx % 4 != 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // gap: 0 = valid every cycle, 1 = every other cycle, 2 = random gaps
  task automatic run_bits(int kind, int nbits, int gap);
    int idx = 0;
    while (idx < nbits) begin
      if ((gap == 1 && (cyc % 2 == 0)) || (gap == 2 && $urandom_range(0, 3) == 0)) begin
        drive(1'($urandom_range(0, 1)), 1'b0);
      end else begin
        drive(pat_bit(kind, idx), 1'b1);
        idx++;
      end
    end
    drive(1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && expq.size() > 0; i++) @(negedge clk);
    check("drain", expq.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    bit_valid = 1'b0;
    #1;
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_sat", sat, 0);
    hist.delete();
    expq.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("init_dout", dout, 0);
    check("init_valid", dout_valid, 0);
    check("init_sat", sat, 0);
    rst_n = 1'b1;

    run_bits(0, 6 * R, 0);   drain();  // full-scale +1 saturates to max
    do_reset();
    run_bits(1, 6 * R, 0);   drain();  // full-scale -1 maps to min, no clip
    do_reset();
    run_bits(2, 6 * R, 0);   drain();  // alternating -> zero
    do_reset();
    run_bits(3, 40 * R, 1);  drain();  // 1110 with gaps; integrators wrap many times
    do_reset();
    run_bits(4, 20 * R, 2);  drain();  // random bits, random gaps
    do_reset();

    // Reset mid-block at cnt = 30, after one completed output so dout is non-zero.
    run_bits(0, R + 30, 0);  drain();
    do_reset();
    run_bits(3, 3 * R, 0);   drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sigma_delta_decimator.md
# sigma_delta_decimator

- Third-order CIC (sinc³) decimator that turns a 1-bit sigma-delta stream back into signed BW-bit PCM samples.
- It is the receive/reconstruction end of our sigma-delta DAC path. It is used for loopback verification of the modulator and as the digital back-end of a 1-bit sigma-delta ADC front-end.
- The decimation ratio is a power of two. One output sample is produced per R accepted input bits, with saturating rescale to BW bits.

## Interface

- BW, 16, output sample width (signed two's complement)
- DEC_LOG2, 6, log2 of decimation ratio R (R = 2**DEC_LOG2); constraint 3*DEC_LOG2 >= BW-1
- clk_i  input  1  clock
- rst_ni  input  1  reset; one clock; reset is asynchronous and active-low
- bit_i  input  1  sigma-delta bit; 1 = +1, 0 = -1
- bit_valid_i  input  1  qualifies bit_i; bit sampled on rising clk_i when high
- dout_o  output  BW  decimated signed sample, held between updates
- dout_valid_o  output  1  one-cycle strobe, dout_o/sat_o updated this cycle
- sat_o  output  1  sample in dout_o was clipped; updated with dout_valid_o, held otherwise

## Operation

- Internal width W = 2 + 3*DEC_LOG2 (default 20). All integrator and comb arithmetic is signed W-bit, modulo 2**W. Wrap-around in the integrators is intentional and must not be saturated.
- Input map: x = +1 if bit_i = 1, else -1, sign-extended to W.
- Integrators run only on cycles with bit_valid_i = 1, as a registered cascade:
  - i1 <= i1 + x
  - i2 <= i2 + i1 (old value)
  - i3 <= i3 + i2 (old value)
  - With bit_valid_i = 0, all integrators and the counter hold.
- Decimation counter cnt, DEC_LOG2 bits:
  - Increments on each accepted bit and wraps R-1 -> 0.
  - An accepted bit with cnt = R-1 sets internal dec_stb for the next cycle.
- On a dec_stb cycle, the comb chain updates (three differential stages, delay 1 at the decimated rate):
  - c1 = i3 - d1; c2 = c1 - d2; c3 = c2 - d3
  - d1 <= i3; d2 <= c1; d3 <= c2
  - Combs hold otherwise.
- Rescale:
  - y = c3 >>> (3*DEC_LOG2 - (BW-1)), arithmetic shift (floor).
  - Saturate y to [-(2**(BW-1)), 2**(BW-1)-1]. sat_o = 1 iff clipping occurred.
  - Full-scale +1 input gives +2**(3*DEC_LOG2) before shift, which saturates to max. Full-scale -1 input maps exactly to min with no clip.
- Filter gain is R³, DC-exact. Nulls at multiples of fs_in/R, so any input pattern periodic with period dividing R yields the exact scaled mean.

## Timing

- Reset (rst_ni low, asynchronous assert) clears i1..i3, d1..d3, cnt, dec_stb, dout_o = 0, dout_valid_o = 0, sat_o = 0.
- Deassertion is synchronous to clk_i via an external synchroniser (not in this block). Reset mid-block discards the partial block; counting restarts at cnt = 0.
- Latency:
  - Edge n accepts the R-th bit of a block.
  - dec_stb is high in cycle n..n+1.
  - Edge n+1 registers dout_o and sat_o and raises dout_valid_o for exactly one cycle.
- dout_valid_o never asserts on consecutive cycles (R >= 2). Output period is exactly R accepted bits, independent of gaps in bit_valid_i.
- A bit accepted on the same edge that dec_stb is consumed is counted normally in the next block. There are no dropped or double-counted bits.
- Settling: the first 3 outputs after reset are transients. From the 4th dout_valid_o onward, the output equals the steady-state filter response.
- No backpressure: downstream must accept dout_o in the dout_valid_o cycle.

## Test plan

- Reset, then bit_i = 1, bit_valid_i = 1 continuously (defaults) -> dout_valid_o every 64 cycles, one cycle wide. From the 4th output: dout_o = 32767, sat_o = 1.
- bit_i = 0 continuously -> from the 4th output: dout_o = -32768, sat_o = 0.
- bit_i alternating 1,0 -> from the 4th output: dout_o = 0, sat_o = 0.
- Repeating 1,1,1,0 with bit_valid_i high only every other cycle -> outputs every 128 clk cycles. From the 4th output: dout_o = 16384, sat_o = 0. Check dout_valid_o lands one edge after the 64th accepted bit.
- Pull rst_ni low asynchronously mid-block (cnt = 30) between edges -> dout_o, dout_valid_o, sat_o are 0 immediately. After release, the first dout_valid_o comes exactly 64 accepted bits later.
- Long run (≥ 2**20 bits) of 1,1,1,0 -> integrators wrap with dout_o remaining 16384 and no glitch at wrap.
